// File: rtl/phase_diff_pkg.sv
// Shared RFNoC phase constants; the default width is common to the
// phase accumulator and the phase differentiator.
package phase_diff_pkg;

  localparam int PHASE_WIDTH = 16;

endpackage

// File: rtl/phase_diff_axis_skid_reg.sv
// Generic registered 2-entry AXI-Stream skid stage (main + skid register).
// Upstream ready is a registered flag and never looks at downstream ready.
module axis_skid_reg #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_fire;
  logic             load_main;

  assign i_ready = !skid_valid;

  always_comb begin
    in_fire   = i_valid && !skid_valid;
    load_main = !o_valid || o_ready;
  end

  // Main refills from the skid first so order is preserved; the skid only
  // catches a beat when main is full and not draining this cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load_main) begin
      if (skid_valid) begin
        o_valid    <= 1'b1;
        o_data     <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        o_valid <= 1'b1;
        o_data  <= i_data;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= i_data;
    end
  end

endmodule

// File: rtl/phase_diff.sv
// Phase differentiator: turns a stream of phase samples into per-sample
// wrapping increments, restarting history at every packet boundary.
import phase_diff_pkg::*;

module phase_diff #(
  parameter int WIDTH = PHASE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic [WIDTH:0]   skid_out;

  assign accept = i_tvalid && i_tready;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= ST_FIRST;
      prev  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        prev <= i_tdata;
      end
    end
  end

  // Subtraction wraps modulo one turn, so crossing the +/- half-turn
  // boundary yields the short-way increment rather than a huge jump.
  always_comb begin
    state_next = state;
    diff       = '0;
    if (state == ST_RUN) begin
      diff = i_tdata - prev;
    end
    if (accept) begin
      state_next = i_tlast ? ST_FIRST : ST_RUN;
    end
  end

  axis_skid_reg #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .i_data ({i_tlast, diff}),
    .i_valid(i_tvalid),
    .i_ready(i_tready),
    .o_data (skid_out),
    .o_valid(o_tvalid),
    .o_ready(o_tready)
  );

  assign {o_tlast, o_tdata} = skid_out;

endmodule

// File: tb/tb_phase_diff.sv
// Directed bench for phase_diff: ramp, wrap, packet boundary, stall depth,
// clear/reset flushes, then randomized backpressure against a queue model.
module tb_phase_diff;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [W-1:0] i_tdata;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [W:0]   exp_q[$];
  logic         mdl_first;
  logic [W-1:0] mdl_prev;

  always #5 clk = ~clk;

  phase_diff #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .i_tdata (i_tdata),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l);
    i_tvalid = v;
    i_tdata  = d;
    i_tlast  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic rdy, input logic v,
                           input logic [W-1:0] d, input logic l);
    checkFlag({tag, ".i_tready"}, i_tready, rdy);
    checkFlag({tag, ".o_tvalid"}, o_tvalid, v);
    if (v) begin
      checkOutput({tag, ".o_tdata"}, o_tdata, d);
      checkFlag({tag, ".o_tlast"}, o_tlast, l);
    end
  endtask

  // Called only when an output transfer is about to happen at the next edge.
  task automatic popCompare();
    logic [W:0] e;
    checkFlag("bp.beat_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("bp.o_tdata", o_tdata, e[W-1:0]);
      checkFlag("bp.o_tlast", o_tlast, e[W]);
    end
  endtask

  initial begin
    logic         stalled;
    logic [W:0]   held;
    logic         r0;
    logic [W-1:0] rd;
    logic         rv;
    logic         rl;

    reset    = 1'b1;
    clear    = 1'b0;
    o_tready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkFlag("reset.o_tvalid", o_tvalid, 1'b0);
    checkFlag("reset.o_tlast", o_tlast, 1'b0);
    checkOutput("reset.o_tdata", o_tdata, 16'h0000);
    checkFlag("reset.i_tready", i_tready, 1'b1);
    reset = 1'b0;

    applyStimulus(1'b1, 16'd0, 1'b0);   @(negedge clk);
    checkBeat("ramp0", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd100, 1'b0); @(negedge clk);
    checkBeat("ramp1", 1'b1, 1'b1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'd200, 1'b0); @(negedge clk);
    checkBeat("ramp2", 1'b1, 1'b1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'd300, 1'b1); @(negedge clk);
    checkBeat("ramp3", 1'b1, 1'b1, 16'd100, 1'b1);

    applyStimulus(1'b1, 16'h7FF0, 1'b0); @(negedge clk);
    checkBeat("wrap0", 1'b1, 1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h8010, 1'b0); @(negedge clk);
    checkBeat("wrap1", 1'b1, 1'b1, 16'h0020, 1'b0);
    applyStimulus(1'b1, 16'h0000, 1'b1); @(negedge clk);
    checkBeat("wrap2", 1'b1, 1'b1, 16'h7FF0, 1'b1);
    applyStimulus(1'b1, 16'h8000, 1'b0); @(negedge clk);
    checkBeat("wrap3", 1'b1, 1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h7FFF, 1'b1); @(negedge clk);
    checkBeat("wrap4", 1'b1, 1'b1, 16'hFFFF, 1'b1);

    applyStimulus(1'b1, 16'd10, 1'b0);  @(negedge clk);
    checkBeat("pkt0", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd20, 1'b1);  @(negedge clk);
    checkBeat("pkt1", 1'b1, 1'b1, 16'd10, 1'b1);
    applyStimulus(1'b1, 16'd500, 1'b0); @(negedge clk);
    checkBeat("pkt2", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd510, 1'b1); @(negedge clk);
    checkBeat("pkt3", 1'b1, 1'b1, 16'd10, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);      @(negedge clk);
    checkBeat("pkt_idle", 1'b1, 1'b0, '0, 1'b0);

    // Stall: two beats fit (main + skid), the third waits for the drain.
    o_tready = 1'b0;
    applyStimulus(1'b1, 16'd1000, 1'b0); @(negedge clk);
    checkBeat("stall0", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd1003, 1'b0); @(negedge clk);
    checkBeat("stall1", 1'b0, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd1010, 1'b1); @(negedge clk);
    checkBeat("stall2", 1'b0, 1'b1, 16'd0, 1'b0);
    o_tready = 1'b1;
    #1;
    checkFlag("stall.ready_not_comb", i_tready, 1'b0);
    @(negedge clk);
    checkBeat("drain0", 1'b1, 1'b1, 16'd3, 1'b0);
    @(negedge clk);
    checkBeat("drain1", 1'b1, 1'b1, 16'd7, 1'b1);
    applyStimulus(1'b0, '0, 1'b0); @(negedge clk);
    checkBeat("drain_idle", 1'b1, 1'b0, '0, 1'b0);

    // Clear mid-packet while a beat is held; the beat offered during clear is ignored.
    applyStimulus(1'b1, 16'd5, 1'b0);  @(negedge clk);
    checkBeat("clr0", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd15, 1'b0); @(negedge clk);
    checkBeat("clr1", 1'b1, 1'b1, 16'd10, 1'b0);
    o_tready = 1'b0;
    clear    = 1'b1;
    applyStimulus(1'b1, 16'd99, 1'b0); @(negedge clk);
    clear = 1'b0;
    checkBeat("clr_flush", 1'b1, 1'b0, '0, 1'b0);
    checkOutput("clr_flush.o_tdata", o_tdata, 16'd0);
    o_tready = 1'b1;
    applyStimulus(1'b1, 16'd40, 1'b0); @(negedge clk);
    checkBeat("clr2", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd45, 1'b1); @(negedge clk);
    checkBeat("clr3", 1'b1, 1'b1, 16'd5, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);     @(negedge clk);
    checkBeat("clr_idle", 1'b1, 1'b0, '0, 1'b0);

    o_tready = 1'b0;
    applyStimulus(1'b1, 16'd5, 1'b0);  @(negedge clk);
    checkBeat("rst0", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd15, 1'b0); @(negedge clk);
    checkBeat("rst1", 1'b0, 1'b1, 16'd0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 16'd999, 1'b0); @(negedge clk);
    reset = 1'b0;
    checkBeat("rst_flush", 1'b1, 1'b0, '0, 1'b0);
    checkOutput("rst_flush.o_tdata", o_tdata, 16'd0);
    o_tready = 1'b1;
    applyStimulus(1'b1, 16'd40, 1'b0); @(negedge clk);
    checkBeat("rst2", 1'b1, 1'b1, 16'd0, 1'b0);
    applyStimulus(1'b1, 16'd45, 1'b1); @(negedge clk);
    checkBeat("rst3", 1'b1, 1'b1, 16'd5, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);     @(negedge clk);

    // Random backpressure: handshakes are decided here, before the next edge.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    mdl_first = 1'b1;
    mdl_prev  = '0;
    stalled   = 1'b0;
    held      = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (stalled) begin
        checkFlag("bp.hold_valid", o_tvalid, 1'b1);
        checkOutput("bp.hold_data", o_tdata, held[W-1:0]);
        checkFlag("bp.hold_last", o_tlast, held[W]);
      end
      rv = 1'($urandom_range(0, 1));
      rd = W'($urandom);
      rl = ($urandom_range(0, 5) == 0);
      applyStimulus(rv, rd, rl);
      o_tready = 1'($urandom_range(0, 1));
      r0 = i_tready;
      o_tready = ~o_tready;
      #1;
      checkFlag("bp.ready_not_comb", i_tready, r0);
      o_tready = ~o_tready;
      #1;
      if (i_tvalid && i_tready) begin
        exp_q.push_back({i_tlast, mdl_first ? {W{1'b0}} : i_tdata - mdl_prev});
        mdl_prev  = i_tdata;
        mdl_first = i_tlast;
      end
      if (o_tvalid && o_tready) popCompare();
      stalled = o_tvalid && !o_tready;
      held    = {o_tlast, o_tdata};
      @(negedge clk);
    end

    applyStimulus(1'b0, '0, 1'b0);
    o_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (o_tvalid) popCompare();
      @(negedge clk);
    end
    checkFlag("bp.all_drained", exp_q.size() == 0, 1'b1);
    checkFlag("bp.final_idle", o_tvalid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
